// File: rtl/cic_decim_ctrl.sv
// Decimation controller for a CIC filter: generates the comb-stage strobe, discards
// warm-up samples after start or rate change, and presents samples on a valid/ready port.
module cic_decim_ctrl #(
    parameter int OW        = 19,
    parameter int N         = 3,
    parameter int RW        = 6,
    parameter int R_DEFAULT = 16
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic [RW-1:0] i_rate,
    input  logic          i_rate_load,
    output logic          o_comb_stb,
    input  logic [OW-1:0] i_comb_data,
    output logic [OW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_overrun,
    output logic          o_warm
);
    localparam int WW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_phase;
    logic [RW-1:0] r_rate;
    logic [RW-1:0] r_pend;
    logic          r_pend_flag;
    logic [WW-1:0] r_warm_cnt;
    logic          r_comb_stb;
    logic          r_stb_run;
    logic [OW-1:0] r_data;
    logic          r_valid;
    logic          r_overrun;
    logic          w_wrap;

    // Rates below 2 would make the strobe permanent; force a minimum of 2.
    function automatic logic [RW-1:0] clamp_rate(input logic [RW-1:0] r);
        return (r < RW'(2)) ? RW'(2) : r;
    endfunction

    assign w_wrap = (r_state != S_IDLE) && (r_phase == r_rate - RW'(1));

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_warm_cnt  <= '0;
            r_rate      <= clamp_rate(RW'(R_DEFAULT));
            r_pend      <= RW'(R_DEFAULT);
            r_pend_flag <= 1'b0;
            r_comb_stb  <= 1'b0;
            r_stb_run   <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // The strobe is emitted even if i_enable drops on the same cycle.
            r_comb_stb <= w_wrap;
            r_stb_run  <= w_wrap && (r_state == S_RUN);

            if (i_rate_load) begin
                r_pend      <= i_rate;
                r_pend_flag <= 1'b1;
            end

            // Capture edge: a full holding register with no accept drops the new sample.
            if (r_stb_run) begin
                if (!r_valid || i_ready) begin
                    r_data  <= i_comb_data;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            if (r_state == S_IDLE) begin
                r_phase    <= '0;
                r_warm_cnt <= '0;
                r_rate     <= clamp_rate(r_pend);
                if (!i_rate_load) begin
                    r_pend_flag <= 1'b0;
                end
                if (i_enable) begin
                    r_state <= S_WARMUP;
                end
            end else if (!i_enable) begin
                r_state    <= S_IDLE;
                r_phase    <= '0;
                r_warm_cnt <= '0;
            end else if (w_wrap) begin
                r_phase <= '0;
                if (r_pend_flag) begin
                    // New rate restarts the comb history, so warm up again.
                    r_rate     <= clamp_rate(r_pend);
                    r_state    <= S_WARMUP;
                    r_warm_cnt <= '0;
                    if (!i_rate_load) begin
                        r_pend_flag <= 1'b0;
                    end
                end else if (r_state == S_WARMUP) begin
                    if (r_warm_cnt == WW'(N - 1)) begin
                        r_state    <= S_RUN;
                        r_warm_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WW'(1);
                    end
                end
            end else begin
                r_phase <= r_phase + RW'(1);
            end
        end
    end

    assign o_comb_stb = r_comb_stb;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_overrun  = r_overrun;
    assign o_warm     = (r_state == S_WARMUP);

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Scoreboard bench for cic_decim_ctrl: strobe schedule planned arithmetically per run
// segment, samples modelled as a one-deep holding buffer fed by the random comb data.
module tb_cic_decim_ctrl;
    localparam int OW = 19;
    localparam int N  = 3;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [RW-1:0] i_rate;
    logic          i_rate_load;
    logic          o_comb_stb;
    logic [OW-1:0] i_comb_data;
    logic [OW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_overrun;
    logic          o_warm;

    cic_decim_ctrl #(.OW(OW), .N(N), .RW(RW), .R_DEFAULT(16)) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_rate      (i_rate),
        .i_rate_load (i_rate_load),
        .o_comb_stb  (o_comb_stb),
        .i_comb_data (i_comb_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_overrun   (o_overrun),
        .o_warm      (o_warm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic run;
        logic warm;
    } stb_t;

    stb_t          exp_stb[int];
    logic [OW-1:0] sq[$];
    int            cyc   = 0;
    int            n_chk = 0;
    int            n_err = 0;
    int            mode  = 0;
    bit            mon_en = 1'b0;
    bit            m_full = 1'b0;
    bit            m_ovr  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    // Strobe k of a segment entered at cycle e lands at e+k*r; the first N are warm-up.
    function automatic void plan(input int e, input int r, input int last, input logic lw);
        stb_t s;
        for (int k = 1; e + k * r <= last; k++) begin
            s.run  = (k > N);
            s.warm = (e + k * r == last) ? lw : (k < N);
            exp_stb[e + k * r] = s;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic run_en(input int r, input int m);
        int t;
        t = cyc;
        plan(t + 1, r, t + m + 1, 1'b0);
        i_enable = 1'b1;
        repeat (m) step();
        i_enable = 1'b0;
    endtask

    // Per-cycle drivers for comb data and ready.
    initial forever begin
        @(posedge clk);
        #1;
        i_comb_data = OW'($urandom);
        case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'($urandom_range(1));
            2:       i_ready = 1'b0;
            default: i_ready = exp_stb.exists(cyc) ? exp_stb[cyc].run : 1'b0;
        endcase
    end

    // Monitor and reference model.
    initial forever begin
        stb_t e;
        bit   run;
        bit   full_n;
        @(negedge clk);
        if (mon_en) begin
            run = 1'b0;
            if (exp_stb.exists(cyc)) begin
                e = exp_stb[cyc];
                exp_stb.delete(cyc);
                chk("comb_stb", 32'(o_comb_stb), 32'(1));
                chk("warm_at_stb", 32'(o_warm), 32'(e.warm));
                run = e.run;
            end else begin
                chk("stb_quiet", 32'(o_comb_stb), 32'(0));
            end
            chk("valid", 32'(o_valid), 32'(m_full));
            chk("overrun", 32'(o_overrun), 32'(m_ovr));
            if (i_reset) begin
                m_full = 1'b0;
                m_ovr  = 1'b0;
                sq.delete();
            end else begin
                if (m_full && i_ready) begin
                    chk("data", 32'(o_data), 32'(sq[0]));
                    void'(sq.pop_front());
                    full_n = 1'b0;
                end else begin
                    full_n = m_full;
                end
                if (run) begin
                    if (!full_n) begin
                        sq.push_back(i_comb_data);
                        full_n = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                m_full = full_n;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        i_reset     = 1'b1;
        i_enable    = 1'b0;
        i_rate      = '0;
        i_rate_load = 1'b0;
        i_ready     = 1'b1;
        i_comb_data = '0;
        repeat (3) step();
        i_reset = 1'b0;
        chk("rst_stb", 32'(o_comb_stb), 32'(0));
        chk("rst_valid", 32'(o_valid), 32'(0));
        chk("rst_data", 32'(o_data), 32'(0));
        chk("rst_overrun", 32'(o_overrun), 32'(0));
        chk("rst_warm", 32'(o_warm), 32'(0));
        mon_en = 1'b1;

        // Basic run at R=16, enable dropped exactly on a run strobe.
        mode = 0;
        run_en(16, 16 * 8);
        repeat (8) step();

        // Ready only on capture cycles: accept and capture coincide.
        mode = 3;
        run_en(16, 16 * 6 + 5);
        mode = 0;
        repeat (8) step();

        // Ready held low: second capture overruns, first sample kept.
        mode = 2;
        run_en(16, 16 * 7 + 3);
        chk("ovr_sticky", 32'(o_overrun), 32'(1));
        mode = 1;
        repeat (20) step();

        // Rate change 16 -> 8 loaded mid-frame.
        t = cyc;
        plan(t + 1, 16, t + 97, 1'b1);
        plan(t + 97, 8, t + 153, 1'b0);
        i_enable = 1'b1;
        wait_until(t + 84);
        i_rate      = RW'(8);
        i_rate_load = 1'b1;
        step();
        i_rate_load = 1'b0;
        wait_until(t + 152);
        i_enable = 1'b0;
        repeat (10) step();

        // Clamp: requested rate 0 runs at 2.
        i_rate      = RW'(0);
        i_rate_load = 1'b1;
        step();
        i_rate_load = 1'b0;
        step();
        step();
        run_en(2, 20);
        repeat (6) step();

        // Reset mid-run with a simultaneous rate load; R_DEFAULT must return.
        t = cyc;
        plan(t + 1, 2, t + 25, 1'b0);
        i_enable = 1'b1;
        wait_until(t + 25);
        i_reset     = 1'b1;
        i_rate      = RW'(5);
        i_rate_load = 1'b1;
        step();
        i_reset     = 1'b0;
        i_rate_load = 1'b0;
        i_enable    = 1'b0;
        chk("abort_stb", 32'(o_comb_stb), 32'(0));
        chk("abort_valid", 32'(o_valid), 32'(0));
        chk("abort_data", 32'(o_data), 32'(0));
        chk("abort_overrun", 32'(o_overrun), 32'(0));
        chk("abort_warm", 32'(o_warm), 32'(0));
        step();
        run_en(16, 16 * 6);
        repeat (10) step();

        chk("strobes_left", 32'(exp_stb.num()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 The block SHALL have parameter OW, default 19, giving the sample width of the comb chain output.
REQ-002 The block SHALL have parameter N, default 3, giving the number of comb stages, which is also the warm-up discard count.
REQ-003 The block SHALL have parameter RW, default 6, giving the width of the decimation-rate field.
REQ-004 The block SHALL have parameter R_DEFAULT, default 16, giving the decimation factor loaded at reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single PDM-rate clock; all logic is on the rising edge.
REQ-006 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port i_enable, input, 1 bit: run request; low holds the block idle.
REQ-008 The block SHALL have port i_rate, input, RW bits: requested decimation factor R.
REQ-009 The block SHALL have port i_rate_load, input, 1 bit: one-cycle pulse that latches i_rate as the pending rate.
REQ-010 The block SHALL have port o_comb_stb, output, 1 bit: one-cycle decimation strobe to the comb stages, replacing a separate lr clock.
REQ-011 The block SHALL have port i_comb_data, input, OW bits: output of the last comb stage.
REQ-012 The block SHALL have port o_data, output, OW bits: held decimated sample.
REQ-013 The block SHALL have port o_valid, input/output pair with i_ready (output o_valid 1 bit, input i_ready 1 bit): sample handshake.
REQ-014 The block SHALL have port o_overrun, output, 1 bit: sticky flag set when a sample is lost.
REQ-015 The block SHALL have port o_warm, output, 1 bit: high while in the WARMUP state.

Function
REQ-016 The block SHALL implement states IDLE, WARMUP and RUN.
- IDLE->WARMUP when i_enable=1.
- WARMUP->RUN after N strobes.
- Any state->IDLE on the cycle after i_enable=0.
REQ-017 The phase counter SHALL count 0..R-1 in WARMUP and RUN, wrap to 0, and be held at 0 in IDLE.
REQ-018 o_comb_stb SHALL be high for exactly one cycle when phase==R-1 in WARMUP or RUN, giving one strobe every R clocks; the first strobe occurs R clocks after entering WARMUP.
REQ-019 The warm-up counter SHALL count strobes in WARMUP; the Nth strobe transitions to RUN, and samples from warm-up strobes SHALL NOT be presented.
REQ-020 In RUN, on the cycle after each strobe (capture cycle), i_comb_data SHALL be registered into o_data and o_valid set, giving a latency of 1 clk from strobe to o_valid.
REQ-021 o_valid SHALL clear on any cycle with o_valid=1 and i_ready=1.
REQ-022 o_data SHALL be stable while o_valid=1.
REQ-023 If the capture cycle coincides with o_valid=1 and i_ready=1, the new sample SHALL be loaded and o_valid SHALL remain 1, with no loss.
REQ-024 If the capture cycle finds o_valid=1 and i_ready=0, the new sample SHALL be dropped, o_data SHALL be kept, and o_overrun SHALL be set; o_overrun is cleared only by reset.
REQ-025 i_rate_load SHALL latch i_rate into a pending register; a later load before application SHALL overwrite it.
REQ-026 Pending rate application:
- In IDLE, the pending rate SHALL be applied immediately.
- Otherwise it SHALL be applied on the cycle the phase wraps (strobe cycle), after which the block SHALL re-enter WARMUP with the warm-up counter cleared.
REQ-027 The effective R SHALL be clamped so that a requested R<2 is used as 2.
REQ-028 Leaving to IDLE SHALL clear the phase and warm-up counters.
REQ-029 A pending capture SHALL still complete in the cycle after a final strobe, and o_valid/o_data SHALL be retained until consumed.
REQ-030 An i_enable drop in the same cycle as a strobe SHALL still emit that strobe.

Reset
REQ-031 While i_reset=1 at a clock edge, the block SHALL enter IDLE with the following values:
- phase=0, warm-up count=0.
- Active and pending rate = R_DEFAULT.
- o_comb_stb=0, o_data=0, o_valid=0, o_overrun=0, o_warm=0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight capture and pending rate.
REQ-033 Reset SHALL take priority over all other inputs.

Verification
REQ-034 Bench scenario, basic run: reset, then i_enable=1, i_ready=1, R=16 -> o_comb_stb at clocks 16, 32, 48 after enable, o_warm falls after the 3rd strobe, the first o_valid 1 clk after the 4th strobe, then one o_valid every 16 clocks.
REQ-035 Bench scenario, overrun: i_ready=0 in RUN -> first sample held, o_overrun=1 from the second capture cycle, o_data unchanged; raising i_ready then consumes the held sample.
REQ-036 Bench scenario, simultaneous accept and capture: i_ready=1 exactly on the capture cycle with o_valid=1 -> new data loaded, o_valid stays 1, o_overrun stays 0.
REQ-037 Bench scenario, rate change: i_rate=8 loaded mid-frame at R=16 -> remaining strobe at R=16 phase, then WARMUP with 3 strobes spaced 8 clocks, then RUN.
REQ-038 Bench scenario, clamp and abort: i_rate=0 load -> strobe every 2 clocks; i_reset pulse in RUN -> all outputs 0 the next cycle and R=16 restored.
